// File: rtl/timer_cmd_arbiter.sv
// Round-robin arbiter that serialises requester commands onto a single shared timer.
// Each timer command input gets a clean high pulse followed by an equal low gap.
module timer_cmd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_W     = 32,
    parameter int PULSE_LEN = 2,
    parameter int CAP_WAIT  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_an_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [2*NUM_REQ-1:0]     req_cmd_i,
    input  logic [NUM_REQ-1:0]       req_alarm_en_i,
    input  logic [CNT_W*NUM_REQ-1:0] req_alarm_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [CNT_W-1:0]         rsp_data_o,
    output logic                     start_o,
    output logic                     capture_o,
    output logic                     rst_capture_o,
    output logic                     alarm_en_o,
    output logic [CNT_W-1:0]         alarm_o,
    input  logic [CNT_W-1:0]         captured_i
);

    localparam int MAX_CNT = (PULSE_LEN > CAP_WAIT) ? PULSE_LEN : CAP_WAIT;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAP_WAIT - 1);
    localparam logic [OW-1:0] LAST_IDX   = OW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_WAIT_CAP,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        CMD_START       = 2'b00,
        CMD_CAPTURE     = 2'b01,
        CMD_RST_CAPTURE = 2'b10,
        CMD_ALARM       = 2'b11
    } cmd_e;

    state_e              state_q, state_d;
    cmd_e                cmd_q, next_cmd, grant_cmd;
    logic [CW-1:0]       cnt_q;
    logic [OW-1:0]       ptr_q, owner_q, next_owner, grant_idx;
    logic                grant_found, accept;
    logic [CNT_W-1:0]    grant_alarm;
    logic                grant_alarm_en;
    logic                start_d, capture_d, rst_capture_d;
    logic [NUM_REQ-1:0]  rsp_valid_d;

    // Search from the pointer upwards with wrap-around; first valid requester wins.
    always_comb begin : arbitrate
        logic [31:0] idx_full;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx_full    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_full = 32'(ptr_q) + 32'(i);
            if (idx_full >= 32'(NUM_REQ)) begin
                idx_full = idx_full - 32'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[idx_full[OW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx_full[OW-1:0];
            end
        end
    end

    always_comb begin : payload_mux
        grant_cmd      = CMD_START;
        grant_alarm    = '0;
        grant_alarm_en = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == OW'(k)) begin
                grant_cmd      = cmd_e'(req_cmd_i[2*k +: 2]);
                grant_alarm    = req_alarm_i[CNT_W*k +: CNT_W];
                grant_alarm_en = req_alarm_en_i[k];
            end
        end
    end

    // Nothing may be accepted while either reset is active, so ready stays 0 then.
    assign accept = (state_q == ST_IDLE) && grant_found && rst_an_i && !rst_i;

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q inside {ST_PULSE, ST_GAP, ST_WAIT_CAP}) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = (grant_cmd == CMD_ALARM) ? ST_RESP : ST_PULSE;
            ST_PULSE:    if (cnt_q == PULSE_LAST) state_d = ST_GAP;
            ST_GAP:      if (cnt_q == PULSE_LAST)
                             state_d = (cmd_q == CMD_CAPTURE) ? ST_WAIT_CAP : ST_RESP;
            ST_WAIT_CAP: if (cnt_q == CAP_LAST) state_d = ST_RESP;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered so the timer sees glitch-free levels.
    always_comb begin
        next_cmd      = accept ? grant_cmd : cmd_q;
        next_owner    = accept ? grant_idx : owner_q;
        req_ready_o   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
        start_d       = (state_d == ST_PULSE) && (next_cmd == CMD_START);
        capture_d     = (state_d == ST_PULSE) && (next_cmd == CMD_CAPTURE);
        rst_capture_d = (state_d == ST_PULSE) && (next_cmd == CMD_RST_CAPTURE);
        rsp_valid_d   = (state_d == ST_RESP) ? (NUM_REQ'(1) << next_owner) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            cmd_q         <= CMD_START;
            owner_q       <= '0;
            ptr_q         <= '0;
            start_o       <= 1'b0;
            capture_o     <= 1'b0;
            rst_capture_o <= 1'b0;
            rsp_valid_o   <= '0;
            rsp_data_o    <= '0;
            alarm_o       <= '0;
            alarm_en_o    <= 1'b0;
        end else if (rst_i) begin
            cmd_q         <= CMD_START;
            owner_q       <= '0;
            ptr_q         <= '0;
            start_o       <= 1'b0;
            capture_o     <= 1'b0;
            rst_capture_o <= 1'b0;
            rsp_valid_o   <= '0;
            rsp_data_o    <= '0;
            alarm_o       <= '0;
            alarm_en_o    <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q   <= grant_cmd;
                owner_q <= grant_idx;
                ptr_q   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + OW'(1);
            end
            if (accept && (grant_cmd == CMD_ALARM)) begin
                alarm_o    <= grant_alarm;
                alarm_en_o <= grant_alarm_en;
            end
            start_o       <= start_d;
            capture_o     <= capture_d;
            rst_capture_o <= rst_capture_d;
            rsp_valid_o   <= rsp_valid_d;
            if ((state_q == ST_WAIT_CAP) && (state_d == ST_RESP)) begin
                rsp_data_o <= captured_i;
            end else if (state_q == ST_RESP) begin
                rsp_data_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_timer_cmd_arbiter.sv
// Directed bench for timer_cmd_arbiter; captured_i follows a free-running cycle
// count so the capture sampling cycle is visible in rsp_data_o.
module tb_timer_cmd_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_an_i;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [7:0]   req_cmd_i;
    logic [3:0]   req_alarm_en_i;
    logic [127:0] req_alarm_i;
    logic [3:0]   req_ready_o;
    logic [3:0]   rsp_valid_o;
    logic [31:0]  rsp_data_o;
    logic         start_o, capture_o, rst_capture_o, alarm_en_o;
    logic [31:0]  alarm_o;
    logic [31:0]  captured_i;
    logic [31:0]  cyc = '0;

    int checks   = 0;
    int failures = 0;
    int low_run  = 1000;
    logic prev_any = 1'b0;

    timer_cmd_arbiter #(.NUM_REQ(4), .CNT_W(32), .PULSE_LEN(2), .CAP_WAIT(4)) dut (
        .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i),
        .req_alarm_en_i(req_alarm_en_i), .req_alarm_i(req_alarm_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .start_o(start_o), .capture_o(capture_o), .rst_capture_o(rst_capture_o),
        .alarm_en_o(alarm_en_o), .alarm_o(alarm_o), .captured_i(captured_i)
    );

    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 32'd1;
    assign captured_i = cyc;

    // Pulses must never overlap, and each rising pulse needs at least two low cycles before it.
    always @(negedge clk_i) begin
        if (!rst_an_i || rst_i) begin
            low_run <= 1000;
        end else if (start_o || capture_o || rst_capture_o) begin
            if (!prev_any) begin
                checks = checks + 1;
                if (low_run < 2) begin
                    failures = failures + 1;
                    $display("[TB] FAIL pulse_gap low_cycles=%0d required>=2", low_run);
                end
            end
            checks = checks + 1;
            if ($countones({start_o, capture_o, rst_capture_o}) != 1) begin
                failures = failures + 1;
                $display("[TB] FAIL pulse_overlap got=%b required one-hot",
                         {start_o, capture_o, rst_capture_o});
            end
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
        prev_any <= start_o || capture_o || rst_capture_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 40 && req_ready_o == 4'b0000; n++) step();
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 40 && rsp_valid_o == 4'b0000; n++) step();
    endtask

    task automatic test_reset();
        rst_an_i = 1'b0; rst_i = 1'b0;
        req_valid_i = 4'b1111; req_cmd_i = '0; req_alarm_en_i = '0; req_alarm_i = '0;
        #12;
        checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready_o); end
        checks++; if (rsp_valid_o !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0000", rsp_valid_o); end
        checks++; if ({start_o, capture_o, rst_capture_o} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses got=%b exp=000", {start_o, capture_o, rst_capture_o}); end
        checks++; if ({alarm_en_o, alarm_o, rsp_data_o} !== 65'd0) begin failures++; $display("[TB] FAIL reset_data got=%h/%h/%h exp=0", alarm_en_o, alarm_o, rsp_data_o); end
        req_valid_i = 4'b0000;
        step();
        rst_an_i = 1'b1;
        step();
    endtask

    task automatic test_start();
        req_valid_i = 4'b0001; req_cmd_i = 8'b00_00_00_00;
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("[TB] FAIL start_ready got=%b exp=0001", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        for (int off = 1; off <= 6; off++) begin
            checks++; if (start_o !== (off <= 2)) begin failures++; $display("[TB] FAIL start_pulse T+%0d got=%b exp=%b", off, start_o, off <= 2); end
            checks++; if (rsp_valid_o !== ((off == 5) ? 4'b0001 : 4'b0000)) begin failures++; $display("[TB] FAIL start_rsp T+%0d got=%b", off, rsp_valid_o); end
            checks++; if ({capture_o, rst_capture_o, rsp_data_o} !== 34'd0) begin failures++; $display("[TB] FAIL start_other T+%0d got=%b%b data=%h exp=0", off, capture_o, rst_capture_o, rsp_data_o); end
            step();
        end
    endtask

    task automatic test_capture();
        logic [31:0] t_acc;
        req_valid_i = 4'b0100; req_cmd_i = 8'b00_01_00_00;
        #1;
        t_acc = cyc;
        checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("[TB] FAIL cap_ready got=%b exp=0100", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        for (int off = 1; off <= 10; off++) begin
            checks++; if (capture_o !== (off <= 2)) begin failures++; $display("[TB] FAIL cap_pulse T+%0d got=%b exp=%b", off, capture_o, off <= 2); end
            checks++; if (rsp_valid_o !== ((off == 9) ? 4'b0100 : 4'b0000)) begin failures++; $display("[TB] FAIL cap_rsp T+%0d got=%b", off, rsp_valid_o); end
            checks++; if (rsp_data_o !== ((off == 9) ? t_acc + 32'd8 : 32'd0)) begin failures++; $display("[TB] FAIL cap_data T+%0d got=%h exp=%h", off, rsp_data_o, (off == 9) ? t_acc + 32'd8 : 32'd0); end
            step();
        end
    endtask

    task automatic test_alarm();
        req_valid_i = 4'b0010; req_cmd_i = 8'b00_00_11_00;
        req_alarm_en_i = 4'b0010; req_alarm_i = '0; req_alarm_i[63:32] = 32'h0000_0040;
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("[TB] FAIL alarm_ready got=%b exp=0010", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        checks++; if (alarm_o !== 32'h40 || alarm_en_o !== 1'b1) begin failures++; $display("[TB] FAIL alarm_out got=%h/%b exp=40/1", alarm_o, alarm_en_o); end
        checks++; if (rsp_valid_o !== 4'b0010) begin failures++; $display("[TB] FAIL alarm_rsp got=%b exp=0010", rsp_valid_o); end
        checks++; if ({start_o, capture_o, rst_capture_o} !== 3'b000) begin failures++; $display("[TB] FAIL alarm_pulses got=%b exp=000", {start_o, capture_o, rst_capture_o}); end
        step();
        checks++; if (rsp_valid_o !== 4'b0000 || alarm_o !== 32'h40 || alarm_en_o !== 1'b1) begin failures++; $display("[TB] FAIL alarm_hold got=%b/%h/%b exp=0000/40/1", rsp_valid_o, alarm_o, alarm_en_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++; if (alarm_o !== 32'h0 || alarm_en_o !== 1'b0) begin failures++; $display("[TB] FAIL softclr_alarm got=%h/%b exp=0/0", alarm_o, alarm_en_o); end
        req_valid_i = 4'b1111; req_cmd_i = 8'b00_01_10_00;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << k;
            wait_ready();
            checks++; if (req_ready_o !== exp) begin failures++; $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready_o, exp); end
            step();
            req_valid_i = req_valid_i & ~exp;
            wait_rsp();
            checks++; if (rsp_valid_o !== exp) begin failures++; $display("[TB] FAIL rr_rsp[%0d] got=%b exp=%b", k, rsp_valid_o, exp); end
            step();
        end
        req_valid_i = 4'b1001; req_cmd_i = 8'b00_00_00_00;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp = (k == 0) ? 4'b0001 : 4'b1000;
            wait_ready();
            checks++; if (req_ready_o !== exp) begin failures++; $display("[TB] FAIL rr2_ready[%0d] got=%b exp=%b", k, req_ready_o, exp); end
            step();
            req_valid_i = req_valid_i & ~exp;
            wait_rsp();
            checks++; if (rsp_valid_o !== exp) begin failures++; $display("[TB] FAIL rr2_rsp[%0d] got=%b exp=%b", k, rsp_valid_o, exp); end
            step();
        end
    endtask

    task automatic test_reset_abort();
        int stray;
        req_valid_i = 4'b0010; req_cmd_i = 8'b00_00_11_00;
        req_alarm_en_i = 4'b0010; req_alarm_i = '0; req_alarm_i[63:32] = 32'h0000_1234;
        wait_ready();
        step();
        req_valid_i = 4'b0000;
        step();
        checks++; if (alarm_o !== 32'h1234) begin failures++; $display("[TB] FAIL abort_alarm_set got=%h exp=1234", alarm_o); end
        req_valid_i = 4'b0100; req_cmd_i = 8'b00_01_00_00;
        #1;
        checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("[TB] FAIL abort_cap_ready got=%b exp=0100", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        checks++; if (capture_o !== 1'b1) begin failures++; $display("[TB] FAIL abort_cap_high got=%b exp=1", capture_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++; if (capture_o !== 1'b0 || rsp_valid_o !== 4'b0000) begin failures++; $display("[TB] FAIL abort_cap_drop got=%b/%b exp=0/0000", capture_o, rsp_valid_o); end
        checks++; if (alarm_o !== 32'h0 || alarm_en_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_alarm_clr got=%h/%b exp=0/0", alarm_o, alarm_en_o); end
        stray = 0;
        for (int n = 0; n < 12; n++) begin
            if (rsp_valid_o !== 4'b0000 || capture_o !== 1'b0) stray++;
            step();
        end
        checks++; if (stray != 0) begin failures++; $display("[TB] FAIL abort_cap_stray got=%0d cycles exp=0", stray); end
        req_valid_i = 4'b1111; req_cmd_i = 8'b00_00_00_00;
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("[TB] FAIL abort_ptr got=%b exp=0001", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        wait_rsp();
        checks++; if (rsp_valid_o !== 4'b0001) begin failures++; $display("[TB] FAIL abort_serve got=%b exp=0001", rsp_valid_o); end
        step();
        req_valid_i = 4'b0010;
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("[TB] FAIL async_ready got=%b exp=0010", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        step();
        step();
        rst_an_i = 1'b0;
        #1;
        checks++; if ({start_o, rsp_valid_o, alarm_en_o} !== 6'd0) begin failures++; $display("[TB] FAIL async_drop got=%b/%b/%b exp=0", start_o, rsp_valid_o, alarm_en_o); end
        step();
        step();
        rst_an_i = 1'b1;
        stray = 0;
        for (int n = 0; n < 10; n++) begin
            if (rsp_valid_o !== 4'b0000 || start_o !== 1'b0) stray++;
            step();
        end
        checks++; if (stray != 0) begin failures++; $display("[TB] FAIL async_stray got=%0d cycles exp=0", stray); end
        req_valid_i = 4'b1000;
        #1;
        checks++; if (req_ready_o !== 4'b1000) begin failures++; $display("[TB] FAIL after_ready got=%b exp=1000", req_ready_o); end
        step();
        req_valid_i = 4'b0000;
        for (int off = 1; off <= 5; off++) begin
            checks++; if (start_o !== (off <= 2)) begin failures++; $display("[TB] FAIL after_pulse T+%0d got=%b exp=%b", off, start_o, off <= 2); end
            checks++; if (rsp_valid_o !== ((off == 5) ? 4'b1000 : 4'b0000)) begin failures++; $display("[TB] FAIL after_rsp T+%0d got=%b", off, rsp_valid_o); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_capture();
        test_alarm();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
